ysyx_23060203_clint: RTL and testbench

YSYX_23060203_CLINT -- requirements
Module: ysyx_23060203_clint

---
 rtl/ysyx_23060203_pkg.sv | 32 +++
 rtl/ysyx_23060203_mtime.sv | 38 +++
 rtl/ysyx_23060203_clint.sv | 160 ++++++++++++++++
 tb/tb_ysyx_23060203_clint.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060203_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060203_pkg
//  Purpose  : Shared AXI response/burst encodings and CLINT FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060203_pkg;

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Read-channel FSM
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_t;

  // Address of the following beat. FIXED repeats the address; every other
  // encoding (WRAP included) simply steps one 32-bit word and wraps at 2^32.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [1:0]  burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_mtime.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060203_mtime
//  Purpose  : Free-running 64-bit mtime counter behind a clock prescaler.
//             mtime advances once every DIV clk cycles (DIV in 1..65535)
//             and wraps silently from 2^64-1 to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_mtime #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mtime
);

  localparam logic [15:0] C_DIV_M1 = 16'(DIV - 1);

  logic [15:0] r_presc;
  logic [63:0] r_mtime;

  // Prescaler and counter; with DIV=1 the prescaler is pinned at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= 16'd0;
      r_mtime <= 64'd0;
    end else if (r_presc == C_DIV_M1) begin
      r_presc <= 16'd0;
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  assign mtime = r_mtime;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_clint.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060203_clint
//  Purpose  : Read-only CLINT exposing the 64-bit mtime over an AXI read
//             channel (AR/R). Each burst is served from a snapshot taken at
//             AR acceptance, so low/high words never tear across a carry.
//             Beats outside the mtime doubleword return zero with DECERR.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_clint
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] MTIME_ADDR = 32'h0200_0000,
  parameter int          DIV        = 1
) (
  input  logic        clk,
  input  logic        rst,
  // AR channel
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // R channel
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  logic [63:0]  w_mtime;

  clint_state_t r_state;
  logic [31:0]  r_addr;
  logic [3:0]   r_id;
  logic [7:0]   r_len;
  logic [1:0]   r_burst;
  logic [7:0]   r_beat;
  logic [63:0]  r_snap;

  logic         r_arready;
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic [1:0]   r_rresp;
  logic         r_rlast;
  logic [3:0]   r_rid;

  ysyx_23060203_mtime #(
    .DIV (DIV)
  ) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .mtime (w_mtime)
  );

  // Handshakes and next-beat bookkeeping
  logic        w_acc;
  logic        w_hs;
  logic [31:0] w_next_addr;
  logic [7:0]  w_next_beat;
  assign w_acc       = arvalid & r_arready;
  assign w_hs        = r_rvalid & rready;
  assign w_next_addr = next_beat_addr(r_addr, r_burst);
  assign w_next_beat = r_beat + 8'd1;

  // Payload of the beat about to be presented: on acceptance it is beat 0
  // from the live mtime (which is also what gets snapshotted), otherwise
  // the following beat from the held snapshot.
  logic [31:0] w_sel_addr;
  logic [63:0] w_sel_snap;
  logic        w_hit;
  logic [31:0] w_data;
  logic [1:0]  w_resp;
  assign w_sel_addr = w_acc ? araddr  : w_next_addr;
  assign w_sel_snap = w_acc ? w_mtime : r_snap;
  assign w_hit      = (w_sel_addr[31:3] == MTIME_ADDR[31:3]);
  assign w_data     = !w_hit       ? 32'd0 :
                      w_sel_addr[2] ? w_sel_snap[63:32] : w_sel_snap[31:0];
  assign w_resp     = w_hit ? RESP_OKAY : RESP_DECERR;

  // Transfer size and byte offset do not affect which word is returned
  logic w_unused_bits;
  assign w_unused_bits = ^{arsize, w_sel_addr[1:0]};

  // Read FSM with registered channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'd0;
      r_id      <= 4'd0;
      r_len     <= 8'd0;
      r_burst   <= BURST_FIXED;
      r_beat    <= 8'd0;
      r_snap    <= 64'd0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rid     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_state   <= ST_RESP;
            r_addr    <= araddr;
            r_id      <= arid;
            r_len     <= arlen;
            r_burst   <= arburst;
            r_beat    <= 8'd0;
            r_snap    <= w_mtime;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_data;
            r_rresp   <= w_resp;
            r_rlast   <= (arlen == 8'd0);
            r_rid     <= arid;
          end
        end
        ST_RESP: begin
          if (w_hs) begin
            if (r_rlast) begin
              r_state   <= ST_IDLE;
              r_arready <= 1'b1;
              r_rvalid  <= 1'b0;
              r_rdata   <= 32'd0;
              r_rresp   <= RESP_OKAY;
              r_rlast   <= 1'b0;
              r_rid     <= 4'd0;
            end else begin
              r_beat  <= w_next_beat;
              r_addr  <= w_next_addr;
              r_rdata <= w_data;
              r_rresp <= w_resp;
              r_rlast <= (w_next_beat == r_len);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arready <= 1'b1;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rid     = r_rid;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_clint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060203_clint
//  Purpose  : Directed self-checking bench for the CLINT read channel.
//             Instance dut runs with DIV=1, dut4 with DIV=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060203_clint;

  localparam logic [1:0] C_FIXED = 2'b00;
  localparam logic [1:0] C_INCR  = 2'b01;

  logic        clk;
  logic        rst;

  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
  logic [31:0] b_araddr, b_rdata;
  logic [3:0]  b_arid, b_rid;
  logic [7:0]  b_arlen;
  logic [2:0]  b_arsize;
  logic [1:0]  b_arburst, b_rresp;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_23060203_clint #(.MTIME_ADDR(32'h0200_0000), .DIV(1)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  ysyx_23060203_clint #(.MTIME_ADDR(32'h0200_0000), .DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .arvalid(b_arvalid), .arready(b_arready), .araddr(b_araddr), .arid(b_arid),
    .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
    .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rresp(b_rresp),
    .rlast(b_rlast), .rid(b_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One rising edge, then return on the falling edge where outputs are sampled
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one AR request on dut, take it through one edge, then drop it
  task automatic ar(input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [1:0] burst);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arburst = burst;
    arsize = 3'd2;
    tick();
    arvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0;
    b_arvalid = 1'b0; b_araddr = '0; b_arid = '0; b_arlen = '0; b_arsize = '0;
    b_arburst = '0; b_rready = 1'b0;
    @(negedge clk);
    repeat (3) tick();

    // ---- reset state ----
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rlast",   64'(rlast),   64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_rresp",   64'(rresp),   64'd0);
    chk("rst_rid",     64'(rid),     64'd0);
    chk("rst_mtime",   dut.u_mtime.r_mtime, 64'd0);
    chk("rst_arready4", 64'(b_arready), 64'd1);

    // ---- single read after 10 cycles ----
    rst = 1'b0;
    repeat (10) tick();
    chk("t1_mtime", dut.u_mtime.r_mtime, 64'd10);
    chk("t1_arready", 64'(arready), 64'd1);
    ar(32'h0200_0000, 4'd2, 8'd0, C_INCR);
    chk("t1_rvalid",  64'(rvalid),  64'd1);
    chk("t1_rdata",   64'(rdata),   64'd10);
    chk("t1_rlast",   64'(rlast),   64'd1);
    chk("t1_rresp",   64'(rresp),   64'd0);
    chk("t1_rid",     64'(rid),     64'd2);
    chk("t1_arready_resp", 64'(arready), 64'd0);
    rready = 1'b1;
    tick();
    chk("t1_idle_rvalid",  64'(rvalid),  64'd0);
    chk("t1_idle_arready", 64'(arready), 64'd1);
    chk("t1_idle_rlast",   64'(rlast),   64'd0);

    // ---- 2-beat INCR across a low-word carry ----
    force dut.u_mtime.r_mtime = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_mtime.r_mtime;
    ar(32'h0200_0000, 4'd5, 8'd1, C_INCR);
    chk("t2_b0_rdata", 64'(rdata), 64'h0000_0000_FFFF_FFFF);
    chk("t2_b0_rid",   64'(rid),   64'd5);
    chk("t2_b0_rlast", 64'(rlast), 64'd0);
    chk("t2_b0_rresp", 64'(rresp), 64'd0);
    tick();
    chk("t2_b1_rdata", 64'(rdata), 64'd0);
    chk("t2_b1_rlast", 64'(rlast), 64'd1);
    chk("t2_b1_rid",   64'(rid),   64'd5);
    chk("t2_carry",    64'(dut.u_mtime.r_mtime[63:32]), 64'd1);
    tick();
    chk("t2_idle", 64'(rvalid), 64'd0);

    // ---- high word then overrun into DECERR ----
    ar(32'h0200_0004, 4'd3, 8'd2, C_INCR);
    chk("t3_b0_rdata", 64'(rdata), 64'd1);
    chk("t3_b0_rresp", 64'(rresp), 64'd0);
    chk("t3_b0_rlast", 64'(rlast), 64'd0);
    tick();
    chk("t3_b1_rdata", 64'(rdata), 64'd0);
    chk("t3_b1_rresp", 64'(rresp), 64'd3);
    chk("t3_b1_rlast", 64'(rlast), 64'd0);
    tick();
    chk("t3_b2_rdata", 64'(rdata), 64'd0);
    chk("t3_b2_rresp", 64'(rresp), 64'd3);
    chk("t3_b2_rlast", 64'(rlast), 64'd1);
    chk("t3_b2_rid",   64'(rid),   64'd3);
    tick();
    chk("t3_idle", 64'(rvalid), 64'd0);

    // ---- FIXED burst repeats the same word ----
    force dut.u_mtime.r_mtime = 64'h1234_5678_9ABC_DEF0;
    #1;
    release dut.u_mtime.r_mtime;
    ar(32'h0200_0000, 4'd1, 8'd1, C_FIXED);
    chk("t4_b0_rdata", 64'(rdata), 64'h9ABC_DEF0);
    chk("t4_b0_rlast", 64'(rlast), 64'd0);
    tick();
    chk("t4_b1_rdata", 64'(rdata), 64'h9ABC_DEF0);
    chk("t4_b1_rresp", 64'(rresp), 64'd0);
    chk("t4_b1_rlast", 64'(rlast), 64'd1);
    tick();

    // ---- 64-bit wrap ----
    force dut.u_mtime.r_mtime = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_mtime.r_mtime;
    tick();
    chk("t5_wrap", dut.u_mtime.r_mtime, 64'd0);

    // ---- DIV=4 with a 7-cycle R stall ----
    force dut4.u_mtime.r_mtime = 64'd100;
    force dut4.u_mtime.r_presc = 16'd0;
    #1;
    release dut4.u_mtime.r_mtime;
    release dut4.u_mtime.r_presc;
    b_arvalid = 1'b1; b_araddr = 32'h0200_0000; b_arid = 4'd7; b_arlen = 8'd1;
    b_arburst = C_INCR; b_arsize = 3'd2;
    tick();
    b_arvalid = 1'b0;
    chk("t6_rvalid", 64'(b_rvalid), 64'd1);
    chk("t6_rdata",  64'(b_rdata),  64'd100);
    chk("t6_rlast",  64'(b_rlast),  64'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t6_stall_rdata",   64'(b_rdata),   64'd100);
      chk("t6_stall_rlast",   64'(b_rlast),   64'd0);
      chk("t6_stall_rid",     64'(b_rid),     64'd7);
      chk("t6_stall_rvalid",  64'(b_rvalid),  64'd1);
      chk("t6_stall_arready", 64'(b_arready), 64'd0);
      chk("t6_stall_mtime",   dut4.u_mtime.r_mtime, 64'(100 + (i + 1) / 4));
    end
    b_rready = 1'b1;
    tick();
    chk("t6_b1_rdata", 64'(b_rdata), 64'd0);
    chk("t6_b1_rlast", 64'(b_rlast), 64'd1);
    tick();
    chk("t6_idle", 64'(b_rvalid), 64'd0);

    // ---- reset in the middle of a 4-beat burst ----
    ar(32'h0200_0000, 4'd9, 8'd3, C_INCR);
    tick();
    chk("t7_b1_rlast", 64'(rlast), 64'd0);
    chk("t7_b1_rvalid", 64'(rvalid), 64'd1);
    rst = 1'b1;
    tick();
    chk("t7_rst_rvalid",  64'(rvalid),  64'd0);
    chk("t7_rst_arready", 64'(arready), 64'd1);
    chk("t7_rst_rlast",   64'(rlast),   64'd0);
    chk("t7_rst_mtime",   dut.u_mtime.r_mtime, 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("t7_post_rvalid", 64'(rvalid), 64'd0);
    ar(32'h0200_0000, 4'd1, 8'd0, C_INCR);
    chk("t7_fresh_rdata", 64'(rdata), 64'd5);
    chk("t7_fresh_rlast", 64'(rlast), 64'd1);
    tick();
    chk("t7_fresh_idle", 64'(rvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
